// File: rtl/lmu_ram_burst_master.sv
// lmu_ram_burst_master: read/write burst initiator for the single-port LMU SRAM.
// Fixed-latency read returns land in a credit-managed 4-entry response FIFO.
module lmu_ram_burst_master #(
    parameter int NUM_WORDS = 1024,
    parameter int RD_LAT    = 1,
    parameter int LEN_W     = 8,
    localparam int AW       = $clog2(NUM_WORDS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [AW-1:0]    cmd_addr_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic             wdata_valid_i,
    output logic             wdata_ready_o,
    input  logic [31:0]      wdata_i,
    input  logic [3:0]       wbe_i,
    output logic             rdata_valid_o,
    input  logic             rdata_ready_i,
    output logic [31:0]      rdata_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             req_o,
    output logic             we_o,
    output logic [AW-1:0]    addr_o,
    output logic [31:0]      wdata_o,
    output logic [3:0]       be_o,
    input  logic [31:0]      rdata_i
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     addr_q;
    logic [LEN_W-1:0]  rem_q;
    logic              done_q;
    logic [RD_LAT-1:0] pipe_q;
    logic [31:0]       fifo_mem [4];
    logic [1:0]        wr_ptr, rd_ptr;
    logic [2:0]        fifo_cnt;
    logic [2:0]        inflight;

    logic cmd_fire, wr_beat, rd_issue;
    logic credit_ok, push, pop, last_pop;

    assign cmd_fire  = cmd_valid_i && (state_q == IDLE);
    assign wr_beat   = (state_q == WRITE) && wdata_valid_i;
    assign credit_ok = (fifo_cnt + inflight) < 3'd4;
    assign rd_issue  = (state_q == READ) && credit_ok;
    assign push      = pipe_q[RD_LAT-1];
    assign pop       = rdata_valid_o && rdata_ready_i;
    // Burst is over once nothing is in flight and the final entry leaves
    assign last_pop  = (inflight == 3'd0) &&
                       (fifo_cnt == 3'd0 || (fifo_cnt == 3'd1 && pop));

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + {2'b00, pipe_q[i]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_valid_i) state_d = cmd_we_i ? WRITE : READ;
            WRITE:   if (wr_beat && rem_q == '0) state_d = IDLE;
            READ:    if (rd_issue && rem_q == '0) state_d = DRAIN;
            DRAIN:   if (last_pop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_o   = 1'b0;
        wdata_ready_o = 1'b0;
        req_o         = 1'b0;
        we_o          = 1'b0;
        addr_o        = addr_q;
        wdata_o       = '0;
        be_o          = '0;
        unique case (state_q)
            IDLE: cmd_ready_o = 1'b1;
            WRITE: begin
                wdata_ready_o = 1'b1;
                req_o         = wdata_valid_i;
                we_o          = 1'b1;
                wdata_o       = wdata_i;
                be_o          = wbe_i;
            end
            READ:    req_o = credit_ok;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q <= '0;
            rem_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (wr_beat && rem_q == '0) ||
                      (state_q == DRAIN && last_pop);
            if (cmd_fire) begin
                addr_q <= cmd_addr_i;
                rem_q  <= cmd_len_i;
            end else if (wr_beat || rd_issue) begin
                addr_q <= addr_q + AW'(1);
                rem_q  <= rem_q - LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_q   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            pipe_q[0] <= rd_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            fifo_cnt <= fifo_cnt + {2'b00, push} - {2'b00, pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr] <= rdata_i;
    end

    assign rdata_valid_o = (fifo_cnt != 3'd0);
    assign rdata_o       = rdata_valid_o ? fifo_mem[rd_ptr] : '0;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;

endmodule

// File: tb/tb_lmu_ram_burst_master.sv
// tb_lmu_ram_burst_master: RD_LAT=1 and RD_LAT=2 instances run in lockstep
// against a word-array reference model with randomized bursts.
module tb_lmu_ram_burst_master;

    localparam int NUM_WORDS = 1024;
    localparam int AW        = 10;
    localparam int LEN_W     = 8;
    localparam int NI        = 2;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic [3:0]    be;
    } wbeat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             cmd_valid   = 1'b0;
    logic             cmd_we      = 1'b0;
    logic [AW-1:0]    cmd_addr    = '0;
    logic [LEN_W-1:0] cmd_len     = '0;
    logic             wdata_valid = 1'b0;
    logic [31:0]      wdata       = '0;
    logic [3:0]       wbe         = '0;
    logic             rdata_ready = 1'b0;

    logic          cmd_ready   [NI];
    logic          wdata_ready [NI];
    logic          rdata_valid [NI];
    logic [31:0]   rdata       [NI];
    logic          busy        [NI];
    logic          done        [NI];
    logic          req         [NI];
    logic          we          [NI];
    logic [AW-1:0] addr        [NI];
    logic [31:0]   sram_wdata  [NI];
    logic [3:0]    be          [NI];

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        logic [31:0] mem [NUM_WORDS];
        logic [31:0] rpipe [2];
        logic [31:0] srd;

        initial begin
            for (int i = 0; i < NUM_WORDS; i++) mem[i] = init_word(i);
        end

        always @(posedge clk) begin
            if (req[g] && we[g]) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[g][b]) mem[addr[g]][8*b +: 8] = sram_wdata[g][8*b +: 8];
                end
            end
            if (req[g] && !we[g]) rpipe[0] <= mem[addr[g]];
            rpipe[1] <= rpipe[0];
        end

        assign srd = rpipe[g];

        lmu_ram_burst_master #(
            .NUM_WORDS(NUM_WORDS),
            .RD_LAT   (g + 1),
            .LEN_W    (LEN_W)
        ) dut (
            .clk_i        (clk),
            .rst_i        (rst),
            .cmd_valid_i  (cmd_valid),
            .cmd_ready_o  (cmd_ready[g]),
            .cmd_we_i     (cmd_we),
            .cmd_addr_i   (cmd_addr),
            .cmd_len_i    (cmd_len),
            .wdata_valid_i(wdata_valid),
            .wdata_ready_o(wdata_ready[g]),
            .wdata_i      (wdata),
            .wbe_i        (wbe),
            .rdata_valid_o(rdata_valid[g]),
            .rdata_ready_i(rdata_ready),
            .rdata_o      (rdata[g]),
            .busy_o       (busy[g]),
            .done_o       (done[g]),
            .req_o        (req[g]),
            .we_o         (we[g]),
            .addr_o       (addr[g]),
            .wdata_o      (sram_wdata[g]),
            .be_o         (be[g]),
            .rdata_i      (srd)
        );
    end

    logic [31:0]   ref_mem [NUM_WORDS];
    wbeat_t        exp_w  [$];
    logic [AW-1:0] exp_ra [$];
    logic [31:0]   exp_r  [$];
    int wi [NI];
    int rai [NI];
    int ri [NI];
    int outst [NI];
    int first_cyc [NI];
    int last_pop [NI];
    int done_cyc [NI];
    int done_cnt [NI];
    int exp_done = 0;
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%08h expected 0x%08h",
                     tag, $time, got, exp);
        end
    endtask

    task automatic clear_model();
        exp_w  = {};
        exp_ra = {};
        exp_r  = {};
        for (int g = 0; g < NI; g++) begin
            wi[g] = 0; rai[g] = 0; ri[g] = 0; outst[g] = 0;
            first_cyc[g] = -1; last_pop[g] = 0; done_cyc[g] = 0;
        end
    endtask

    // Negedge observation of both instances against the expected queues
    task automatic sample();
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            if (!rst) begin
                if (req[g] && we[g]) begin
                    if (wi[g] < exp_w.size()) begin
                        check("wr_addr", 32'(addr[g]), 32'(exp_w[wi[g]].a));
                        check("wr_data", sram_wdata[g], exp_w[wi[g]].d);
                        check("wr_be", 32'(be[g]), 32'(exp_w[wi[g]].be));
                    end else begin
                        check("wr_spurious", wi[g], exp_w.size());
                    end
                    wi[g]++;
                end
                if (req[g] && !we[g]) begin
                    outst[g]++;
                    check("rd_outstanding_le4", 32'(outst[g] <= 4), 1);
                    check("rd_be", 32'(be[g]), 0);
                    if (rai[g] < exp_ra.size())
                        check("rd_addr", 32'(addr[g]), 32'(exp_ra[rai[g]]));
                    else
                        check("rd_spurious_req", rai[g], exp_ra.size());
                    rai[g]++;
                end
                if (rdata_valid[g] && first_cyc[g] < 0) first_cyc[g] = cyc;
                if (rdata_valid[g] && rdata_ready) begin
                    outst[g]--;
                    if (ri[g] < exp_r.size())
                        check("rd_data", rdata[g], exp_r[ri[g]]);
                    else
                        check("rd_spurious_data", ri[g], exp_r.size());
                    ri[g]++;
                    last_pop[g] = cyc;
                end
                if (done[g]) begin
                    done_cnt[g]++;
                    done_cyc[g] = cyc;
                end
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    // gmode: 0 gap-free, 1 random gaps, 2 valid pattern 1,0,0,1,1
    task automatic do_write(input logic [AW-1:0] a, input int len,
                            input int be_sel, input int data_sel,
                            input int gmode);
        logic [31:0] d [$];
        logic [3:0]  b [$];
        logic [4:0]  pat;
        logic        v;
        wbeat_t      wb;
        int          k;
        int          c;
        pat = 5'b11001;
        for (int i = 0; i <= len; i++) begin
            wb.a  = a + AW'(i);
            wb.d  = (data_sel >= 0) ? 32'(data_sel + i) : $urandom;
            wb.be = (be_sel >= 0) ? 4'(be_sel) : 4'($urandom_range(0, 15));
            d.push_back(wb.d);
            b.push_back(wb.be);
            exp_w.push_back(wb);
            for (int j = 0; j < 4; j++) begin
                if (wb.be[j]) ref_mem[wb.a][8*j +: 8] = wb.d[8*j +: 8];
            end
        end
        exp_done++;
        cmd_valid   = 1'b1;
        cmd_we      = 1'b1;
        cmd_addr    = a;
        cmd_len     = LEN_W'(len);
        wdata_valid = 1'($urandom_range(0, 1));
        wdata       = $urandom;
        sample();
        for (int g = 0; g < NI; g++) check("wr_cmd_ready", cmd_ready[g], 1);
        advance();
        cmd_valid = 1'b0;
        k = 0;
        c = 0;
        while (k <= len && c < 200) begin
            if (gmode == 0)      v = 1'b1;
            else if (gmode == 1) v = ($urandom_range(0, 2) != 0);
            else                 v = (c < 5) ? pat[c] : 1'b1;
            wdata_valid = v;
            wdata       = v ? d[k] : $urandom;
            wbe         = v ? b[k] : 4'($urandom_range(0, 15));
            sample();
            for (int g = 0; g < NI; g++) begin
                check("wr_req", req[g], v);
                check("wr_ready", wdata_ready[g], 1);
            end
            advance();
            if (v) k++;
            c++;
        end
        check("wr_beats", k, len + 1);
        wdata_valid = 1'($urandom_range(0, 1));
        wdata       = $urandom;
        sample();
        for (int g = 0; g < NI; g++) begin
            check("wr_done", done[g], 1);
            check("wr_idle", {cmd_ready[g], busy[g], wdata_ready[g]}, 3'b100);
        end
        advance();
        wdata_valid = 1'b0;
    endtask

    // rmode: 0 always ready, 1 ready 1-of-3 cycles, 2 random ready
    task automatic do_read(input logic [AW-1:0] a, input int len,
                           input int rmode);
        int t0;
        int budget;
        for (int i = 0; i <= len; i++) begin
            exp_ra.push_back(a + AW'(i));
            exp_r.push_back(ref_mem[a + AW'(i)]);
        end
        exp_done++;
        for (int g = 0; g < NI; g++) first_cyc[g] = -1;
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = a;
        cmd_len   = LEN_W'(len);
        t0        = cyc;
        sample();
        for (int g = 0; g < NI; g++) check("rd_cmd_ready", cmd_ready[g], 1);
        advance();
        cmd_valid = 1'b0;
        budget = 0;
        while ((done_cnt[0] != exp_done || done_cnt[1] != exp_done) &&
               budget < 500) begin
            if (rmode == 0)      rdata_ready = 1'b1;
            else if (rmode == 1) rdata_ready = ((cyc % 3) == 0);
            else                 rdata_ready = 1'($urandom_range(0, 1));
            tick();
            budget++;
        end
        check("rd_timeout", 32'(budget < 500), 1);
        for (int g = 0; g < NI; g++) begin
            check("rd_first_latency", first_cyc[g] - t0, 2 + g + 1);
            check("rd_done_after_pop", done_cyc[g] - last_pop[g], 1);
            check("rd_all_popped", ri[g], exp_r.size());
            if (rmode == 0)
                check("rd_sustained", last_pop[g] - first_cyc[g], len);
        end
    endtask

    task automatic abort_read(input logic [AW-1:0] a);
        for (int i = 0; i < 8; i++) begin
            exp_ra.push_back(a + AW'(i));
            exp_r.push_back(ref_mem[a + AW'(i)]);
        end
        rdata_ready = 1'b0;
        cmd_valid   = 1'b1;
        cmd_we      = 1'b0;
        cmd_addr    = a;
        cmd_len     = LEN_W'(7);
        tick();
        cmd_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
        sample();
        for (int g = 0; g < NI; g++) begin
            check("abort_cmd_ready", cmd_ready[g], 1);
            check("abort_quiet",
                  {rdata_valid[g], busy[g], req[g], done[g]}, 4'b0000);
        end
        advance();
        rdata_ready = 1'b1;
        repeat (6) tick();
    endtask

    initial begin
        logic [AW-1:0] ra;
        for (int i = 0; i < NUM_WORDS; i++) ref_mem[i] = init_word(i);
        for (int g = 0; g < NI; g++) done_cnt[g] = 0;
        clear_model();
        wdata = 32'hDEADBEEF;
        wbe   = 4'hF;
        rst   = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        sample();
        for (int g = 0; g < NI; g++) begin
            check("rst_cmd_ready", cmd_ready[g], 1);
            check("rst_ctl", {req[g], we[g], wdata_ready[g], rdata_valid[g],
                              busy[g], done[g]}, 6'b0);
            check("rst_addr", 32'(addr[g]), 0);
            check("rst_be", 32'(be[g]), 0);
            check("rst_wdata", sram_wdata[g], 0);
            check("rst_rdata", rdata[g], 0);
        end
        advance();

        do_write(AW'(16), 3, 15, 32'hA0, 0);
        do_read(AW'(16), 3, 0);
        do_read(AW'(8), 15, 1);
        do_write(AW'(NUM_WORDS - 2), 2, 3, -1, 0);
        do_read(AW'(NUM_WORDS - 2), 2, 0);
        do_write(AW'(64), 2, 15, -1, 2);
        do_read(AW'(64), 2, 2);
        abort_read(AW'(16));
        do_read(AW'(16), 7, 0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0)
                ra = AW'(NUM_WORDS - $urandom_range(1, 4));
            else
                ra = AW'($urandom_range(0, NUM_WORDS - 1));
            if ($urandom_range(0, 1) == 1)
                do_write(ra, $urandom_range(0, 15), -1, -1,
                         $urandom_range(0, 1));
            else
                do_read(ra, $urandom_range(0, 15), $urandom_range(0, 2));
            repeat ($urandom_range(0, 2)) tick();
        end

        for (int g = 0; g < NI; g++) check("done_count", done_cnt[g], exp_done);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
